uart_echo_engine: RTL and testbench

Buffered, parametrised message transform stage between the UART receiver wrapper and the UART transmitter wrapper. It accepts BYTES-byte messages from the receiver and applies a per-message case transform, selected at enqueue time. It queues messages in a DEPTH-entry FIFO and issues each one to the transmitter as a single-cycle pulse, with a TAG_W-bit tag appended. It replaces the fixed two-byte, unbuffered echo logic at chip top, which lost messages whenever the transmitter was busy.

---
 rtl/uart_echo_engine.sv | 146 ++++++++++++++
 tb/tb_uart_echo_engine.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_engine.sv
// Buffered echo stage: per-byte case transform at enqueue, DEPTH-entry FIFO, guarded tx pulses.
// Optional macro ECHO_SEQ_TAG_EN: tag is a wrapping sequence number instead of the constant 1.
module uart_echo_engine #(
  parameter int unsigned BYTES = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned GUARD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [8*BYTES-1:0]       rx_data,
  input  logic [1:0]               mode,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [8*BYTES+TAG_W-1:0] tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 8 * BYTES;
  localparam int unsigned TW = DW + TAG_W;

  typedef enum logic [1:0] {StIdle, StSend, StGuard} state_e;

  state_e            state_q, state_d;
  logic [2:0]        guard_q, guard_d;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [DW-1:0]     mem_q [DEPTH];
  logic [DW-1:0]     rx_xf;
  logic [TAG_W-1:0]  tag;
  logic              tx_valid_q;
  logic [TW-1:0]     tx_data_q;
  logic              overflow_q;
  logic [7:0]        drop_count_q;
  logic              full, empty, push, pop, drop;

  function automatic logic [7:0] xform_byte(input logic [7:0] b, input logic [1:0] m);
    logic is_upper;
    logic is_lower;
    is_upper = (b >= 8'h41) && (b <= 8'h5A);
    is_lower = (b >= 8'h61) && (b <= 8'h7A);
    xform_byte = b;
    case (m)
      2'd1: begin
        if (is_upper) xform_byte = b + 8'h20;
        else if (is_lower) xform_byte = b - 8'h20;
      end
      2'd2: if (is_lower) xform_byte = b - 8'h20;
      2'd3: if (is_upper) xform_byte = b + 8'h20;
      default: xform_byte = b;
    endcase
  endfunction

  always_comb begin
    rx_xf = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      rx_xf[8*i +: 8] = xform_byte(rx_data[8*i +: 8], mode);
    end
  end

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty = (wptr_q == rptr_q);
  assign push  = rx_valid && !full;
  assign drop  = rx_valid && full;

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && tx_ready) begin
          pop     = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        guard_d = 3'(GUARD);
        state_d = StGuard;
      end
      StGuard: begin
        guard_d = guard_q - 3'd1;
        if (guard_q <= 3'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ECHO_SEQ_TAG_EN
  logic [TAG_W-1:0] seq_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq_q <= '0;
    end else if (pop) begin
      seq_q <= seq_q + 1'b1;
    end
  end

  assign tag = seq_q;
`else
  assign tag = TAG_W'(1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      guard_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      tx_valid_q <= pop;
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= rx_xf;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) begin
        tx_data_q <= {mem_q[rptr_q[AW-1:0]], tag};
        rptr_q    <= rptr_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = wptr_q - rptr_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_echo_engine.sv
// Scoreboard bench for uart_echo_engine: expected messages queued at drive, checked on tx_valid.
module tb_uart_echo_engine;

  localparam int BYTES = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int GUARD = 2;
  localparam int DW    = 8 * BYTES;
  localparam int TW    = DW + TAG_W;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [1:0]    mode = 2'd0;
  logic          tx_ready = 1'b0;
  logic          tx_valid;
  logic [TW-1:0] tx_data;
  logic [PW-1:0] fifo_count;
  logic          overflow;
  logic [7:0]    drop_count;

  uart_echo_engine #(
    .BYTES(BYTES),
    .DEPTH(DEPTH),
    .TAG_W(TAG_W),
    .GUARD(GUARD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .mode      (mode),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int push_cyc = 0;
  int pulse_count = 0;
  int pulse_cyc[$];
  logic [DW-1:0] exp_q[$];
  int model_count = 0;
  int model_drops = 0;
  logic [TAG_W-1:0] seq_m = '0;

  always @(posedge clock) cyc = cyc + 1;

  function automatic logic [7:0] ref_byte(input logic [7:0] b, input logic [1:0] m);
    bit up;
    bit lo;
    up = (b >= 8'h41) && (b <= 8'h5A);
    lo = (b >= 8'h61) && (b <= 8'h7A);
    ref_byte = b;
    if (m == 2'd1 && (up || lo)) ref_byte = b ^ 8'h20;
    if (m == 2'd2 && lo) ref_byte = b & 8'hDF;
    if (m == 2'd3 && up) ref_byte = b | 8'h20;
  endfunction

  function automatic logic [DW-1:0] ref_msg(input logic [DW-1:0] d, input logic [1:0] m);
    ref_msg = '0;
    for (int i = 0; i < BYTES; i++) ref_msg[8*i +: 8] = ref_byte(d[8*i +: 8], m);
  endfunction

  function automatic logic [TAG_W-1:0] exp_tag(input logic [TAG_W-1:0] s);
`ifdef ECHO_SEQ_TAG_EN
    exp_tag = s;
`else
    exp_tag = TAG_W'(1);
`endif
  endfunction

  // Scoreboard: every tx pulse must match the oldest queued expectation.
  always @(posedge clock) begin
    logic [TW-1:0] want;
    #1;
    if (tx_valid === 1'b1) begin
      pulse_count = pulse_count + 1;
      pulse_cyc.push_back(cyc);
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_tx: tx_data=%h, expected no pulse", tx_data);
      end else begin
        want = {exp_q.pop_front(), exp_tag(seq_m)};
        model_count = model_count - 1;
        if (tx_data !== want) begin
          errors = errors + 1;
          $display("FAIL tx_data: got %h, expected %h", tx_data, want);
        end
      end
      seq_m = seq_m + 1'b1;
    end
  end

  task automatic push_msg(input logic [DW-1:0] d, input logic [1:0] m, input logic rdy);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = d;
    mode     = m;
    tx_ready = rdy;
    push_cyc = cyc;
    if (model_count < DEPTH) begin
      exp_q.push_back(ref_msg(d, m));
      model_count = model_count + 1;
    end else if (model_drops < 255) begin
      model_drops = model_drops + 1;
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (pulse_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks = checks + 1;
    if (pulse_count < target) begin
      errors = errors + 1;
      $display("FAIL pulse_timeout: got %0d pulses, expected %0d", pulse_count, target);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_model();
    exp_q.delete();
    pulse_cyc.delete();
    model_count = 0;
    model_drops = 0;
    seq_m       = '0;
  endtask

  task automatic check_reset_values(input string tag);
    checks = checks + 5;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL %s_tx_valid: got %b, expected 0", tag, tx_valid);
    end
    if (tx_data !== '0) begin
      errors++; $display("FAIL %s_tx_data: got %h, expected 0", tag, tx_data);
    end
    if (fifo_count !== '0) begin
      errors++; $display("FAIL %s_fifo_count: got %0d, expected 0", tag, fifo_count);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL %s_overflow: got %b, expected 0", tag, overflow);
    end
    if (drop_count !== 8'd0) begin
      errors++; $display("FAIL %s_drop_count: got %0d, expected 0", tag, drop_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_model();
    idle(3);
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_tx_valid: got %b, expected 0", tx_valid);
    end
    idle(2);
  endtask

  task automatic test_transform();
    logic [DW-1:0] din [5] = '{16'h6142, 16'h2031, 16'h617A, 16'h415A, 16'h7A5B};
    logic [1:0]    md  [5] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [DW-1:0] want[5] = '{16'h4162, 16'h2031, 16'h415A, 16'h617A, 16'h7A5B};
    int lat;
    for (int i = 0; i < 5; i++) begin
      push_msg(din[i], md[i], 1'b1);
      wait_pulses(pulse_count + 1, 10);
      lat = pulse_cyc[pulse_cyc.size()-1] - push_cyc;
      checks = checks + 2;
      if (lat != 2) begin
        errors++; $display("FAIL latency_%0d: got %0d cycles, expected 2", i, lat);
      end
      if (tx_data[TW-1:TAG_W] !== want[i]) begin
        errors++; $display("FAIL xform_%0d: got %h, expected %h", i, tx_data[TW-1:TAG_W], want[i]);
      end
      idle(GUARD + 2);
    end
  endtask

  task automatic test_overflow();
    int base;
    int d;
    tx_ready = 1'b0;
    idle(2);
    for (int i = 0; i < 5; i++) push_msg(DW'(16'h4130 + i), 2'(i % 4), 1'b0);
    @(negedge clock);
    checks = checks + 3;
    if (fifo_count !== PW'(4)) begin
      errors++; $display("FAIL ovf_fifo_count: got %0d, expected 4", fifo_count);
    end
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow);
    end
    if (drop_count !== 8'd1) begin
      errors++; $display("FAIL ovf_drop_count: got %0d, expected 1", drop_count);
    end
    base = pulse_cyc.size();
    tx_ready = 1'b1;
    wait_pulses(pulse_count + 4, 40);
    for (int i = base + 1; i < pulse_cyc.size(); i++) begin
      d = pulse_cyc[i] - pulse_cyc[i-1];
      checks++;
      if (d != GUARD + 2) begin
        errors++; $display("FAIL spacing_%0d: got %0d cycles, expected %0d", i, d, GUARD + 2);
      end
    end
    idle(GUARD + 2);
    checks++;
    if (fifo_count !== '0) begin
      errors++; $display("FAIL drain_fifo_count: got %0d, expected 0", fifo_count);
    end
  endtask

  task automatic test_coincident_drop();
    tx_ready = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) push_msg(DW'(16'h6160 + i), 2'd2, 1'b0);
    // Raise tx_ready with the push so the pop and the drop share one edge.
    push_msg(16'h5A5A, 2'd3, 1'b1);
    @(negedge clock);
    tx_ready = 1'b0;
    checks = checks + 2;
    if (fifo_count !== PW'(3)) begin
      errors++; $display("FAIL coinc_fifo_count: got %0d, expected 3", fifo_count);
    end
    if (drop_count !== 8'(model_drops)) begin
      errors++; $display("FAIL coinc_drop_count: got %0d, expected %0d", drop_count, model_drops);
    end
    idle(GUARD + 2);
    push_msg(16'h3132, 2'd1, 1'b0);
    for (int i = 0; i < 260; i++) push_msg(16'h4242, 2'd0, 1'b0);
    @(negedge clock);
    checks = checks + 3;
    if (drop_count !== 8'd255) begin
      errors++; $display("FAIL sat_drop_count: got %0d, expected 255", drop_count);
    end
    if (fifo_count !== PW'(4)) begin
      errors++; $display("FAIL sat_fifo_count: got %0d, expected 4", fifo_count);
    end
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL sat_overflow: got %b, expected 1", overflow);
    end
    tx_ready = 1'b1;
    wait_pulses(pulse_count + 4, 40);
    idle(GUARD + 2);
  endtask

  task automatic test_seq_tags();
    logic [TAG_W-1:0] last_tag;
`ifdef ECHO_SEQ_TAG_EN
    last_tag = '0;
`else
    last_tag = TAG_W'(1);
`endif
    @(negedge clock);
    reset = 1'b1;
    clear_model();
    idle(2);
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < 17; i++) begin
      push_msg(DW'(16'h6100 + i), 2'd1, 1'b1);
      wait_pulses(pulse_count + 1, 10);
      idle(GUARD + 1);
    end
    checks++;
    if (tx_data[TAG_W-1:0] !== last_tag) begin
      errors++; $display("FAIL tag_17: got %h, expected %h", tx_data[TAG_W-1:0], last_tag);
    end
  endtask

  task automatic test_reset_mid_guard();
    int lat;
    tx_ready = 1'b0;
    idle(2);
    for (int i = 0; i < 5; i++) push_msg(DW'(16'h7170 + i), 2'd1, 1'b0);
    tx_ready = 1'b1;
    wait_pulses(pulse_count + 1, 10);
    idle(2);
    reset = 1'b1;
    clear_model();
    #1;
    check_reset_values("mid_guard");
    idle(2);
    reset = 1'b0;
    idle(10);
    checks++;
    if (fifo_count !== '0) begin
      errors++; $display("FAIL post_abort_fifo_count: got %0d, expected 0", fifo_count);
    end
    push_msg(16'h6142, 2'd1, 1'b1);
    wait_pulses(pulse_count + 1, 10);
    lat = pulse_cyc[pulse_cyc.size()-1] - push_cyc;
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL post_abort_latency: got %0d cycles, expected 2", lat);
    end
    idle(GUARD + 2);
  endtask

  initial begin
    test_reset();
    test_transform();
    test_overflow();
    test_coincident_drop();
    test_seq_tags();
    test_reset_mid_guard();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: got %0d queued, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
